// File: rtl/pipe_mux_n.sv
// N:1 operand-select mux with a registered valid/ready output stage and a one-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining PIPE_MUX_SEL_CHECK_EN.
module pipe_mux_n #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               skid_valid_q, skid_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [WIDTH-1:0]   sel_data_c;
  logic               accept_c;

  // Channel select; an out-of-range select matches no channel and yields zero.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data_c = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign accept_c = in_valid && in_ready_q;

  // Next-state and storage update.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_valid_d = skid_valid_q;

    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          out_data_d  = sel_data_c;
          out_sel_d   = in_sel;
          out_valid_d = 1'b1;
          state_d     = FULL1;
        end
      end
      FULL1: begin
        if (accept_c && out_ready) begin
          out_data_d = sel_data_c;
          out_sel_d  = in_sel;
        end else if (accept_c) begin
          skid_data_d  = sel_data_c;
          skid_sel_d   = in_sel;
          skid_valid_d = 1'b1;
          state_d      = FULL2;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = EMPTY;
        end
      end
      FULL2: begin
        if (out_ready) begin
          out_data_d   = skid_data_q;
          out_sel_d    = skid_sel_q;
          skid_valid_d = 1'b0;
          state_d      = FULL1;
        end
      end
      default: begin
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        state_d      = EMPTY;
      end
    endcase

    // Ready is a pure function of the next registered state, never of this cycle's out_ready.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic sel_oor_c;
  logic sel_err_q;

  assign sel_oor_c = (32'(in_sel) >= NUM_IN);

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept_c && sel_oor_c) begin
      sel_err_q <= 1'b1;
    end
  end

  assign sel_err = sel_err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && accept_c) begin
      assert (!sel_oor_c)
        else $error("pipe_mux_n: accepted out-of-range select %0d", in_sel);
    end
  end
`endif
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
// Randomised bench for pipe_mux_n: a 4-channel and a 3-channel instance share handshakes,
// checked against a two-entry FIFO reference model.
module tb_pipe_mux_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data4;
  logic [95:0]  in_data3;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready4, out_valid4, sel_err4;
  logic [31:0]  out_data4;
  logic [1:0]   out_sel4;
  logic         in_ready3, out_valid3, sel_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;

  logic [31:0]  ch [4];

  typedef struct packed {
    logic [31:0] d4;
    logic [31:0] d3;
    logic [1:0]  s;
  } beat_t;

  beat_t q[$];
  logic  err3_exp;
  int    n_chk;
  int    n_err;

  always #5 clk = ~clk;

  assign in_data3 = in_data4[95:0];

  pipe_mux_n #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data4), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
    .out_sel(out_sel4), .out_valid(out_valid4), .out_ready(out_ready),
    .sel_err(sel_err4)
  );

  pipe_mux_n #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
    .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready),
    .sel_err(sel_err3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("in_ready4", 64'(in_ready4), 64'(q.size() < 2));
    chk("in_ready3", 64'(in_ready3), 64'(q.size() < 2));
    chk("out_valid4", 64'(out_valid4), 64'(q.size() > 0));
    chk("out_valid3", 64'(out_valid3), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data4", 64'(out_data4), 64'(q[0].d4));
      chk("out_data3", 64'(out_data3), 64'(q[0].d3));
      chk("out_sel4", 64'(out_sel4), 64'(q[0].s));
      chk("out_sel3", 64'(out_sel3), 64'(q[0].s));
    end
    chk("sel_err4", 64'(sel_err4), 64'd0);
    chk("sel_err3", 64'(sel_err3), 64'(err3_exp));
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
  task automatic step(input logic v, input logic [1:0] s, input logic r, input logic probe);
    logic  rdy_a;
    logic  acc;
    logic  drn;
    beat_t b;
    in_valid  = v;
    in_sel    = s;
    out_ready = r;
    in_data4  = {ch[3], ch[2], ch[1], ch[0]};
    if (probe) begin
      #1 rdy_a = in_ready4;
      out_ready = ~r;
      in_valid  = ~v;
      #1 chk("ready_comb", 64'(in_ready4), 64'(rdy_a));
      out_ready = r;
      in_valid  = v;
    end
    @(posedge clk);
    acc = v && (q.size() < 2);
    drn = r && (q.size() > 0);
    if (drn) void'(q.pop_front());
    if (acc) begin
      b.d4 = ch[s];
      b.d3 = (s < 2'd3) ? ch[s] : 32'd0;
      b.s  = s;
      q.push_back(b);
`ifdef PIPE_MUX_SEL_CHECK_EN
      if (s == 2'd3) err3_exp = 1'b1;
`endif
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    err3_exp  = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    out_ready = 1'b0;
    ch[0] = 32'hAAAA_0000;
    ch[1] = 32'hBBBB_0001;
    ch[2] = 32'hCCCC_0002;
    ch[3] = 32'hDDDD_0003;
    in_data4 = {ch[3], ch[2], ch[1], ch[0]};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid4), 64'd0);
    chk("rst_in_ready", 64'(in_ready4), 64'd1);
    chk("rst_out_data", 64'(out_data4), 64'd0);
    chk("rst_out_sel", 64'(out_sel4), 64'd0);
    chk("rst_sel_err3", 64'(sel_err3), 64'd0);
    rst_n = 1'b1;

    // Basic select
    step(1'b1, 2'd2, 1'b1, 1'b0);
    chk("basic_data", 64'(out_data4), 64'h0000_0000_CCCC_0002);
    chk("basic_sel", 64'(out_sel4), 64'd2);
    chk("basic_valid", 64'(out_valid4), 64'd1);

    // Streaming at full throughput
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'(i), 1'b1, 1'b1);
      chk("stream_ready", 64'(in_ready4), 64'd1);
    end
    chk("stream_last", 64'(out_data4), 64'h0000_0000_DDDD_0003);
    step(1'b0, 2'd0, 1'b1, 1'b0);

    // Back-pressure into the skid
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b1);
    chk("bp_ready_low", 64'(in_ready4), 64'd0);
    chk("bp_hold", 64'(out_data4), 64'h0000_0000_AAAA_0000);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    chk("bp_hold2", 64'(out_data4), 64'h0000_0000_AAAA_0000);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("bp_drain_b", 64'(out_data4), 64'h0000_0000_BBBB_0001);
    chk("bp_ready_back", 64'(in_ready4), 64'd1);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("bp_empty", 64'(out_valid4), 64'd0);

    // Asynchronous reset while FULL2
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid4), 64'd0);
    chk("mid_rst_ready", 64'(in_ready4), 64'd1);
    chk("mid_rst_valid3", 64'(out_valid3), 64'd0);
    q.delete();
    err3_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);

    // Out-of-range select on the 3-channel instance
    step(1'b1, 2'd3, 1'b1, 1'b0);
    chk("oor_data3", 64'(out_data3), 64'd0);
    chk("oor_valid3", 64'(out_valid3), 64'd1);
    chk("oor_data4", 64'(out_data4), 64'h0000_0000_DDDD_0003);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 2'd0, 1'b1, 1'b0);

    // Random soak with fresh channel data every cycle
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'((i % 97) == 0));
    end

    // Drain whatever is left
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("final_empty", 64'(out_valid4), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
